// File: rtl/argmax_evaluator.sv
// Argmax accuracy evaluator: pairs each network output vector with its teacher
// vector, finds the signed argmax of both, and reports the hit count once per
// BATCH samples.
module argmax_evaluator #(
    parameter int NO    = 2,
    parameter int WD    = 12,
    parameter int BATCH = 100,
    parameter int WC    = 16
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iValid_AM_Output,
    output logic                oReady_AM_Output,
    input  logic [NO*WD-1:0]    iData_AM_Output,
    input  logic                iValid_AS_Teacher,
    output logic                oReady_AS_Teacher,
    input  logic [NO*WD-1:0]    iData_AS_Teacher,
    output logic                oValid_BM_Result,
    input  logic                iReady_BM_Result,
    output logic [WC-1:0]       oData_BM_Result
);

    localparam int WI = (NO > 1) ? $clog2(NO) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, JUDGE, EMIT} state_t;

    state_t                 state_q, state_d;
    logic                   out_full_q, out_full_d;
    logic                   tch_full_q, tch_full_d;
    logic [NO*WD-1:0]       out_hold_q, out_hold_d;
    logic [NO*WD-1:0]       tch_hold_q, tch_hold_d;
    logic signed [WD-1:0]   out_max_q, out_max_d;
    logic signed [WD-1:0]   tch_max_q, tch_max_d;
    logic [WI-1:0]          out_idx_q, out_idx_d;
    logic [WI-1:0]          tch_idx_q, tch_idx_d;
    logic [WI-1:0]          k_q, k_d;
    logic [WC-1:0]          samp_cnt_q, samp_cnt_d;
    logic [WC-1:0]          hit_cnt_q, hit_cnt_d;
    logic                   valid_q, valid_d;
    logic [WC-1:0]          data_q, data_d;

    logic                   out_take_s;
    logic                   tch_take_s;
    logic                   report_take_s;
    logic                   hit_s;
    logic [WC-1:0]          samp_inc_s;
    logic [WC-1:0]          hit_inc_s;
    logic signed [WD-1:0]   out_lane_s;
    logic signed [WD-1:0]   tch_lane_s;

    // Holders accept a beat only while the FSM waits and the slot is free.
    assign oReady_AM_Output  = (state_q == IDLE) && !out_full_q && !iRST;
    assign oReady_AS_Teacher = (state_q == IDLE) && !tch_full_q && !iRST;
    assign out_take_s        = iValid_AM_Output  && oReady_AM_Output;
    assign tch_take_s        = iValid_AS_Teacher && oReady_AS_Teacher;
    assign report_take_s     = valid_q && iReady_BM_Result;

    assign hit_s      = (out_idx_q == tch_idx_q);
    assign samp_inc_s = samp_cnt_q + WC'(1);
    assign hit_inc_s  = hit_cnt_q + {{(WC-1){1'b0}}, hit_s};

    // Lane k of each held vector, compared during the scan.
    assign out_lane_s = $signed(out_hold_q[32'(k_q)*WD +: WD]);
    assign tch_lane_s = $signed(tch_hold_q[32'(k_q)*WD +: WD]);

    assign oValid_BM_Result = valid_q;
    assign oData_BM_Result  = data_q;

    // Next-state and datapath update for capture, scan, judge and report.
    always_comb begin
        state_d    = state_q;
        out_full_d = out_full_q;
        tch_full_d = tch_full_q;
        out_hold_d = out_hold_q;
        tch_hold_d = tch_hold_q;
        out_max_d  = out_max_q;
        tch_max_d  = tch_max_q;
        out_idx_d  = out_idx_q;
        tch_idx_d  = tch_idx_q;
        k_d        = k_q;
        samp_cnt_d = samp_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        valid_d    = valid_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (out_take_s) begin
                    out_full_d = 1'b1;
                    out_hold_d = iData_AM_Output;
                end else begin
                    out_full_d = out_full_q;
                    out_hold_d = out_hold_q;
                end
                if (tch_take_s) begin
                    tch_full_d = 1'b1;
                    tch_hold_d = iData_AS_Teacher;
                end else begin
                    tch_full_d = tch_full_q;
                    tch_hold_d = tch_hold_q;
                end
                if (out_full_q && tch_full_q) begin
                    out_max_d = $signed(out_hold_q[WD-1:0]);
                    tch_max_d = $signed(tch_hold_q[WD-1:0]);
                    out_idx_d = '0;
                    tch_idx_d = '0;
                    k_d       = WI'(1);
                    state_d   = (NO > 1) ? SCAN : JUDGE;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // Strictly greater replaces, so ties keep the lower index.
                if (out_lane_s > out_max_q) begin
                    out_max_d = out_lane_s;
                    out_idx_d = k_q;
                end else begin
                    out_max_d = out_max_q;
                    out_idx_d = out_idx_q;
                end
                if (tch_lane_s > tch_max_q) begin
                    tch_max_d = tch_lane_s;
                    tch_idx_d = k_q;
                end else begin
                    tch_max_d = tch_max_q;
                    tch_idx_d = tch_idx_q;
                end
                k_d = k_q + WI'(1);
                if (k_q == WI'(NO - 1)) begin
                    state_d = JUDGE;
                end else begin
                    state_d = SCAN;
                end
            end
            JUDGE: begin
                hit_cnt_d  = hit_inc_s;
                samp_cnt_d = samp_inc_s;
                out_full_d = 1'b0;
                tch_full_d = 1'b0;
                k_d        = '0;
                if (samp_inc_s == WC'(BATCH)) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    data_d  = hit_inc_s;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                // Report stays stable until accepted; inputs stall meanwhile.
                if (report_take_s) begin
                    state_d    = IDLE;
                    valid_d    = 1'b0;
                    data_d     = '0;
                    samp_cnt_d = '0;
                    hit_cnt_d  = '0;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            out_full_q <= 1'b0;
            tch_full_q <= 1'b0;
            out_hold_q <= '0;
            tch_hold_q <= '0;
            out_max_q  <= '0;
            tch_max_q  <= '0;
            out_idx_q  <= '0;
            tch_idx_q  <= '0;
            k_q        <= '0;
            samp_cnt_q <= '0;
            hit_cnt_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_full_q <= out_full_d;
            tch_full_q <= tch_full_d;
            out_hold_q <= out_hold_d;
            tch_hold_q <= tch_hold_d;
            out_max_q  <= out_max_d;
            tch_max_q  <= tch_max_d;
            out_idx_q  <= out_idx_d;
            tch_idx_q  <= tch_idx_d;
            k_q        <= k_d;
            samp_cnt_q <= samp_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_argmax_evaluator.sv
// Testbench for argmax_evaluator: a 4-lane/batch-3 instance exercised with
// directed and random samples, plus a 1-lane/batch-4 instance.
module tb_argmax_evaluator;

    localparam int WD      = 12;
    localparam int WC      = 16;
    localparam int NO_A    = 4;
    localparam int BATCH_A = 3;
    localparam int NO_B    = 1;
    localparam int BATCH_B = 4;

    logic clk = 1'b0;
    logic rst;

    logic                 a_vo, a_ro, a_vt, a_rt, a_vr, a_rr;
    logic [NO_A*WD-1:0]   a_do, a_dt;
    logic [WC-1:0]        a_dr;
    logic                 b_vo, b_ro, b_vt, b_rt, b_vr, b_rr;
    logic [NO_B*WD-1:0]   b_do, b_dt;
    logic [WC-1:0]        b_dr;

    int n_vec = 0;
    int n_err = 0;
    int m_samples = 0;
    int m_hits = 0;

    always #5 clk = ~clk;

    argmax_evaluator #(.NO(NO_A), .WD(WD), .BATCH(BATCH_A), .WC(WC)) dut_a (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Output(a_vo), .oReady_AM_Output(a_ro), .iData_AM_Output(a_do),
        .iValid_AS_Teacher(a_vt), .oReady_AS_Teacher(a_rt), .iData_AS_Teacher(a_dt),
        .oValid_BM_Result(a_vr), .iReady_BM_Result(a_rr), .oData_BM_Result(a_dr)
    );

    argmax_evaluator #(.NO(NO_B), .WD(WD), .BATCH(BATCH_B), .WC(WC)) dut_b (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Output(b_vo), .oReady_AM_Output(b_ro), .iData_AM_Output(b_do),
        .iValid_AS_Teacher(b_vt), .oReady_AS_Teacher(b_rt), .iData_AS_Teacher(b_dt),
        .oValid_BM_Result(b_vr), .iReady_BM_Result(b_rr), .oData_BM_Result(b_dr)
    );

    // Reference argmax: find the maximum value, then its first position.
    function automatic int argmax4(input logic [NO_A*WD-1:0] v);
        int vals[NO_A];
        int mx;
        for (int i = 0; i < NO_A; i++) vals[i] = int'($signed(v[i*WD +: WD]));
        mx = vals[0];
        foreach (vals[i]) if (vals[i] > mx) mx = vals[i];
        for (int i = 0; i < NO_A; i++) if (vals[i] == mx) return i;
        return -1;
    endfunction

    function automatic logic [NO_A*WD-1:0] pack4(input int l0, l1, l2, l3);
        logic [NO_A*WD-1:0] r;
        r[0*WD +: WD] = WD'(l0);
        r[1*WD +: WD] = WD'(l1);
        r[2*WD +: WD] = WD'(l2);
        r[3*WD +: WD] = WD'(l3);
        return r;
    endfunction

    function automatic logic [NO_A*WD-1:0] rand_vec(input bit narrow);
        logic [NO_A*WD-1:0] r;
        int val;
        for (int i = 0; i < NO_A; i++) begin
            val = narrow ? (int'($urandom_range(0, 4)) - 2) : int'($urandom_range(0, 4095));
            r[i*WD +: WD] = WD'(val);
        end
        return r;
    endfunction

    // One sample on dut_a; lead>0 means teacher leads by lead cycles, lead<0 output leads.
    task automatic run_sample(input logic [NO_A*WD-1:0] ov, input logic [NO_A*WD-1:0] tv,
                              input int lead, input int hold);
        int  budget;
        int  alead;
        bit  o_done;
        bit  t_done;
        bit  rep;
        bit  ox;
        bit  tx;
        int  exp_hits;
        logic [2:0] exp3;
        m_samples++;
        if (argmax4(ov) == argmax4(tv)) m_hits++;
        rep      = (m_samples == BATCH_A);
        exp_hits = m_hits;
        alead    = (lead < 0) ? -lead : lead;
        a_rr     = (hold == 0) || !rep;
        a_do     = ov;
        a_dt     = tv;
        a_vt     = (lead >= 0);
        a_vo     = (lead <= 0);
        o_done   = 1'b0;
        t_done   = 1'b0;
        budget   = 0;
        while (!(o_done && t_done) && budget < 100) begin
            ox = a_vo && a_ro;
            tx = a_vt && a_rt;
            @(negedge clk);
            budget++;
            if (ox) begin o_done = 1'b1; a_vo = 1'b0; end
            if (tx) begin t_done = 1'b1; a_vt = 1'b0; end
            if (budget >= alead) begin
                if (!o_done) a_vo = 1'b1;
                if (!t_done) a_vt = 1'b1;
            end
        end
        n_vec++;
        if (!(o_done && t_done)) begin
            n_err++;
            $display("FAIL accept_timeout got o=%0d t=%0d required both accepted", o_done, t_done);
            a_vo = 1'b0;
            a_vt = 1'b0;
            return;
        end
        // Offsets 0..NO: busy, nothing accepted; offset NO+1: report or idle.
        for (int off = 0; off <= NO_A + 1; off++) begin
            if (off > 0) @(negedge clk);
            exp3 = (off == NO_A + 1) ? (rep ? 3'b100 : 3'b011) : 3'b000;
            n_vec++;
            if ({a_vr, a_ro, a_rt} !== exp3) begin
                n_err++;
                $display("FAIL timing off=%0d {valid,rdyO,rdyT} got=%b required=%b", off, {a_vr, a_ro, a_rt}, exp3);
            end
        end
        if (rep) begin
            n_vec++;
            if (a_dr !== WC'(exp_hits)) begin
                n_err++;
                $display("FAIL report_data got=%0d required=%0d", a_dr, exp_hits);
            end
            if (hold > 0) begin
                a_do = ~ov;
                a_dt = ~tv;
                a_vo = 1'b1;
                a_vt = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    n_vec++;
                    if ({a_vr, a_ro, a_rt, a_dr} !== {3'b100, WC'(exp_hits)}) begin
                        n_err++;
                        $display("FAIL backpressure h=%0d got v/r/r=%b data=%0d required=100 data=%0d",
                                 h, {a_vr, a_ro, a_rt}, a_dr, exp_hits);
                    end
                end
                a_vo = 1'b0;
                a_vt = 1'b0;
                a_rr = 1'b1;
            end
            @(negedge clk);
            n_vec++;
            if ({a_vr, a_ro, a_rt} !== 3'b011) begin
                n_err++;
                $display("FAIL after_report got=%b required=011", {a_vr, a_ro, a_rt});
            end
            m_samples = 0;
            m_hits    = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({a_vr, a_ro, a_rt, a_dr, b_vr, b_ro, b_rt, b_dr} !== {3'b000, WC'(0), 3'b000, WC'(0)}) begin
            n_err++;
            $display("FAIL reset_hold got a=%b/%0d b=%b/%0d required 000/0", {a_vr, a_ro, a_rt}, a_dr, {b_vr, b_ro, b_rt}, b_dr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({a_vr, a_ro, a_rt, b_vr, b_ro, b_rt} !== 6'b011011) begin
            n_err++;
            $display("FAIL reset_release got=%b required=011011", {a_vr, a_ro, a_rt, b_vr, b_ro, b_rt});
        end
        m_samples = 0;
        m_hits    = 0;
    endtask

    task automatic test_basic();
        run_sample(pack4(3, -1, 7, 2), pack4(0, 0, 1, 0), 0, 0);
        run_sample(pack4(9, 1, 2, 3), pack4(0, 0, 5, 0), 0, 0);
        run_sample(pack4(-5, -6, -7, 100), pack4(0, 0, 0, 1), 2, 0);
    endtask

    task automatic test_ties();
        run_sample(pack4(5, 5, -2, 5), pack4(9, 0, 0, 0), -2, 0);
        run_sample(pack4(-8, -3, -3, -9), pack4(0, 1, 0, 0), 1, 0);
        run_sample(pack4(-2048, -2048, 2047, 2047), pack4(0, 0, 0, 1), 0, 0);
    endtask

    task automatic test_back_to_back_stall();
        run_sample(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 0, 0);
        run_sample(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), -3, 0);
        run_sample(pack4(7, 0, 0, 0), pack4(7, 0, 0, 0), 10, 20);
    endtask

    task automatic test_reset_mid();
        run_sample(pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 0, 0);
        a_do = pack4(0, 9, 0, 0);
        a_dt = pack4(0, 9, 0, 0);
        a_vo = 1'b1;
        a_vt = 1'b1;
        a_rr = 1'b1;
        @(negedge clk);
        a_vo = 1'b0;
        a_vt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_samples = 0;
        m_hits    = 0;
        for (int i = 0; i < NO_A + 2; i++) begin
            @(negedge clk);
            n_vec++;
            if ({a_vr, a_ro, a_rt} !== 3'b011) begin
                n_err++;
                $display("FAIL reset_mid i=%0d got=%b required=011", i, {a_vr, a_ro, a_rt});
            end
        end
        run_sample(pack4(0, 0, 3, 0), pack4(0, 0, 3, 0), 0, 0);
        run_sample(pack4(0, 0, 0, 3), pack4(1, 1, 1, 5), 0, 0);
        run_sample(pack4(3, 0, 0, 0), pack4(0, 3, 0, 0), 0, 2);
    endtask

    task automatic test_random();
        logic [NO_A*WD-1:0] ov;
        logic [NO_A*WD-1:0] tv;
        for (int s = 0; s < 30; s++) begin
            ov = rand_vec($urandom_range(0, 1) == 1);
            tv = ($urandom_range(0, 1) == 1) ? ov : rand_vec($urandom_range(0, 1) == 1);
            run_sample(ov, tv, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_single_lane();
        logic [2:0] exp3;
        b_rr = 1'b1;
        for (int s = 0; s < BATCH_B; s++) begin
            b_do = WD'($urandom_range(0, 4095));
            b_dt = WD'($urandom_range(0, 4095));
            b_vo = 1'b1;
            b_vt = 1'b1;
            @(negedge clk);
            b_vo = 1'b0;
            b_vt = 1'b0;
            for (int off = 1; off <= NO_B + 1; off++) begin
                @(negedge clk);
                exp3 = (off == NO_B + 1) ? ((s == BATCH_B - 1) ? 3'b100 : 3'b011) : 3'b000;
                n_vec++;
                if ({b_vr, b_ro, b_rt} !== exp3) begin
                    n_err++;
                    $display("FAIL single_lane s=%0d off=%0d got=%b required=%b", s, off, {b_vr, b_ro, b_rt}, exp3);
                end
            end
        end
        n_vec++;
        if (b_dr !== WC'(BATCH_B)) begin
            n_err++;
            $display("FAIL single_lane_data got=%0d required=%0d", b_dr, BATCH_B);
        end
        @(negedge clk);
        n_vec++;
        if ({b_vr, b_ro, b_rt} !== 3'b011) begin
            n_err++;
            $display("FAIL single_lane_after got=%b required=011", {b_vr, b_ro, b_rt});
        end
    endtask

    initial begin
        rst  = 1'b1;
        a_vo = 1'b0; a_vt = 1'b0; a_rr = 1'b1; a_do = '0; a_dt = '0;
        b_vo = 1'b0; b_vt = 1'b0; b_rr = 1'b1; b_do = '0; b_dt = '0;
        test_reset();
        test_basic();
        test_ties();
        test_back_to_back_stall();
        test_reset_mid();
        test_random();
        test_single_lane();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
